// File: rtl/lib_piso_if.sv
// lib_piso_if: handshake bundle between a word producer, the PISO converter
// and a bit-serial consumer. The converter uses the slave view; whoever
// feeds words and consumes bits uses the master view.
interface lib_piso_if #(
  parameter int lpm_width = 8
);
  logic                 load_valid;
  logic [lpm_width-1:0] data;
  logic                 load_ready;
  logic                 sout;
  logic                 sout_valid;
  logic                 sout_last;
  logic                 sout_ready;

  modport master (
    output load_valid, data, sout_ready,
    input  load_ready, sout, sout_valid, sout_last
  );

  modport slave (
    input  load_valid, data, sout_ready,
    output load_ready, sout, sout_valid, sout_last
  );
endinterface

// File: rtl/lib_piso.sv
// lib_piso: parallel-in / serial-out converter. Accepts one lpm_width-bit
// word, emits it one bit per accepted beat (MSB or LSB first), flags the
// final bit and can take the next word on the same edge as that final beat.
module lib_piso #(
  parameter int lpm_width = 8,
  parameter bit lsb_first = 1'b0
) (
  input  logic        clock,
  input  logic        reset,   // synchronous, active low
  lib_piso_if.slave   bus
);

  localparam int CW = (lpm_width > 1) ? $clog2(lpm_width) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(lpm_width - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t               state_q;
  logic [lpm_width-1:0] sreg_q;
  logic [lpm_width-1:0] sreg_d;
  logic [CW-1:0]        cnt_q;
  logic [CW-1:0]        cnt_d;
  logic                 valid_q;
  logic                 last_q;

  logic at_last;
  logic beat;
  logic load;

  assign at_last = (cnt_q == '0);
  assign beat    = valid_q && bus.sout_ready;
  assign cnt_d   = cnt_q - CW'(1);

  // load_ready is the only combinational output: a finishing word can hand
  // over to the next one without a bubble when the consumer takes its last bit.
  assign bus.load_ready = reset &&
                          ((state_q == IDLE) ||
                           ((state_q == SHIFT) && at_last && bus.sout_ready));
  assign load = bus.load_valid && bus.load_ready;

  // Serial outputs come straight from registered state.
  assign bus.sout       = lsb_first ? sreg_q[0] : sreg_q[lpm_width-1];
  assign bus.sout_valid = valid_q;
  assign bus.sout_last  = last_q;

  // Shift toward the output end, zero-filling the vacated bit.
  always_comb begin
    sreg_d = sreg_q;
    if (lsb_first) begin
      sreg_d = sreg_q >> 1;
    end else begin
      sreg_d = sreg_q << 1;
    end
  end

  // Control FSM with registered serial outputs; reset wins over any handshake.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= IDLE;
      sreg_q  <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (load) begin
            sreg_q  <= bus.data;
            cnt_q   <= CNT_INIT;
            state_q <= SHIFT;
            valid_q <= 1'b1;
            last_q  <= (CNT_INIT == '0);
          end
        end
        SHIFT: begin
          if (beat) begin
            if (at_last) begin
              if (load) begin
                // back-to-back: next word replaces the finished one
                sreg_q <= bus.data;
                cnt_q  <= CNT_INIT;
                last_q <= (CNT_INIT == '0);
              end else begin
                sreg_q  <= sreg_d;
                state_q <= IDLE;
                valid_q <= 1'b0;
                last_q  <= 1'b0;
              end
            end else begin
              sreg_q <= sreg_d;
              cnt_q  <= cnt_d;
              last_q <= (cnt_d == '0);
            end
          end
        end
        default: begin
          state_q <= IDLE;
          valid_q <= 1'b0;
          last_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/lib_piso.md
# lib_piso

Parallel-in / serial-out converter with valid/ready handshakes on both sides. It takes one `lpm_width`-bit word and streams it out one bit per accepted beat, flagging the final bit. It is the unloading counterpart of the N-bit register `lib_ff`. It sits between word-wide DSP datapaths and bit-serial consumers such as serial arithmetic, DAC/serial links and bit-serial distributed-arithmetic stages.

## Interface

Parameters:

- `lpm_width`, default 8: word width; legal range ≥ 1.
- `lsb_first`, default 0: bit order. 0 sends MSB first; 1 sends LSB first.

Ports:

- `clock`, in, 1: single clock; all logic on the rising edge.
- `reset`, in, 1: synchronous, active-low reset, sampled on the rising edge of `clock`.
- `load_valid`, in, 1: `data` holds a word to be serialized.
- `data`, in, `lpm_width`: parallel input word.
- `load_ready`, out, 1: block accepts a word this cycle.
- `sout`, out, 1: serial bit.
- `sout_valid`, out, 1: `sout` is valid.
- `sout_last`, out, 1: current `sout` is the final bit of the word.
- `sout_ready`, in, 1: consumer accepts the bit this cycle.

## Operation

- Internal state:
  - `sreg`: shift register, `lpm_width` bits.
  - `cnt`: remaining-beat counter, width `max(1, $clog2(lpm_width))`.
  - FSM with states `IDLE` and `SHIFT`.
- Load handshake: a load occurs on a clock edge where `load_valid && load_ready`.
- Output handshake: a beat occurs on a clock edge where `sout_valid && sout_ready`.
- IDLE:
  - `load_ready`=1, `sout_valid`=0.
  - On a load: `sreg`←`data`, `cnt`←`lpm_width-1`, next state SHIFT.
- SHIFT:
  - `sout_valid`=1.
  - `sout` = `sreg[lpm_width-1]` when `lsb_first`=0, else `sreg[0]`.
  - `sout_last` = (`cnt`==0).
- Beat, not last: shift `sreg` toward the output end (left for MSB-first, right for LSB-first), zero-filling the vacated bit; `cnt`←`cnt-1`.
- Beat, last:
  - If a load occurs on the same edge, reload `sreg`/`cnt` and stay in SHIFT (back-to-back, no bubble).
  - Otherwise go to IDLE.
- `load_ready` = (state==IDLE) OR (state==SHIFT && `sout_last` && `sout_ready`). This is the only combinational path, from `sout_ready` to `load_ready`.
- No beat (`sout_ready`=0 in SHIFT): `sreg`, `cnt`, `sout`, `sout_last` hold unchanged. `load_valid` and `data` are ignored unless `load_ready`=1.
- `lpm_width`=1: every beat is last, so `sout_last`=1 whenever `sout_valid`=1.

## Timing

- Reset (`reset`=0 at an edge):
  - Next state IDLE; `sreg`=0, `cnt`=0.
  - `sout`=0, `sout_valid`=0, `sout_last`=0.
  - `load_ready` is forced 0 while `reset` is low.
  - Reset overrides every simultaneous load or beat.
- Reset mid-word: the word is discarded, and no further beats of it appear. `load_ready`=1 on the first cycle after reset is released.
- Latency: word loaded at edge k; its first bit is on `sout` with `sout_valid`=1 during the cycle after edge k.
- Throughput: with `sout_ready` held 1 and `load_valid` held 1, one word every `lpm_width` cycles and `sout_valid` never drops.
- `sout`, `sout_valid` and `sout_last` are functions of registered state only (no combinational path from inputs).
- The consumer may toggle `sout_ready` arbitrarily. The bit sequence is unaffected; only its timing stretches.

## Test plan

- Basic: `lpm_width`=8, `lsb_first`=0, `sout_ready`=1, load 0xA5.
  - Required: cycles 1..8 give `sout` = 1,0,1,0,0,1,0,1.
  - `sout_last` is 1 only on cycle 8; cycle 9 shows `sout_valid`=0 and `load_ready`=1.
- Back-pressure: load 0xC3 with `sout_ready` pattern 1,0,0,1,1,0,1,1,1,1,1.
  - Required: accepted bits are 1,1,0,0,0,0,1,1.
  - `sout` is stable during every stalled cycle; the word completes on the 8th accepted beat.
- Back-to-back: `load_valid`=1 continuously with words 0xFF then 0x00, `sout_ready`=1.
  - Required: 8 ones then 8 zeros on 16 consecutive valid cycles.
  - `load_ready`=1 exactly on the last-beat cycle of the first word; no gap in `sout_valid`.
- Bit order: `lsb_first`=1, load 0x01.
  - Required: `sout` = 1,0,0,0,0,0,0,0.
- Reset mid-word: after 3 beats of 0xA5, drive `reset`=0 for one edge.
  - Required: next cycle `sout_valid`=0, `sout`=0, `sout_last`=0.
  - Then `load_ready`=1; a new load of 0x80 yields 1,0,0,0,0,0,0,0.
- Width 1: `lpm_width`=1, alternate loads of 1 and 0 with `load_valid` and `sout_ready` held 1.
  - Required: `sout` toggles every cycle with `sout_last`=1 on each beat, and `load_ready`=1 every cycle.
